// File: rtl/bitty_pkg.sv
// bitty_pkg: constants and types shared by the bitty core sequencing logic.
//   - Opcode encodings carried in instr[1:0].
//   - Branch condition encodings carried in instr[3:2].
//   - Sequencer state enum.
//   - branch_taken(): branch condition evaluation against the last ALU result.
package bitty_pkg;

    localparam logic [1:0] OP_RR   = 2'd0;
    localparam logic [1:0] OP_IMM  = 2'd1;
    localparam logic [1:0] OP_BR   = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    localparam logic [1:0] BR_EQ = 2'd0;
    localparam logic [1:0] BR_GT = 2'd1;
    localparam logic [1:0] BR_LT = 2'd2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_WAIT = 3'd1,
        EXECUTE    = 3'd2,
        UPDATE     = 3'd3,
        HALT       = 3'd4
    } seq_state_t;

    // Each condition code selects one exact full-width value of the last ALU
    // result; condition 3 has no value and is never taken.
    function automatic logic branch_taken(input logic [1:0]  cond,
                                          input logic [15:0] last_result);
        logic taken;
        taken = 1'b0;
        case (cond)
            BR_EQ:   taken = (last_result == 16'd0);
            BR_GT:   taken = (last_result == 16'd1);
            BR_LT:   taken = (last_result == 16'd2);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational next-PC computation for the UPDATE step.
// Ports:
//   i_pc          current program counter
//   i_is_branch   executing instruction is a branch (opcode OP_BR)
//   i_cond        branch condition field, instr[3:2]
//   i_target      branch target field, instr[11:4]
//   i_last_result last latched ALU result
//   o_next_pc     PC value to load at the end of UPDATE
//   o_taken       branch taken indication
module branch_resolve
    import bitty_pkg::*;
(
    input  logic [7:0]  i_pc,
    input  logic        i_is_branch,
    input  logic [1:0]  i_cond,
    input  logic [7:0]  i_target,
    input  logic [15:0] i_last_result,
    output logic [7:0]  o_next_pc,
    output logic        o_taken
);

    logic [7:0] w_pc_inc;

    // 8-bit add wraps naturally: 8'hFF + 1 = 8'h00.
    assign w_pc_inc  = i_pc + 8'd1;
    assign o_taken   = i_is_branch && branch_taken(i_cond, i_last_result);
    assign o_next_pc = o_taken ? i_target : w_pc_inc;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the 8-bit PC and steps each instruction through
// FETCH_WAIT -> EXECUTE -> UPDATE for the bitty core.
// Ports:
//   clk, reset            clock (rising edge) and synchronous active-high reset
//   run                   level enable, sampled only in IDLE and UPDATE
//   mem_req / mem_addr    fetch request and address (address = pc)
//   mem_valid / mem_rdata one-cycle fetch response with instruction word
//   instr / instr_valid   registered instruction and one-cycle pulse on entry to EXECUTE
//   alu_done / alu_result ALU completion pulse and result
//   pc                    current program counter
//   halted                high in HALT
//   fetch_err / exec_err  sticky timeout flags
//   o_dbg_state           current sequencer state
// Handshake: mem_req stays high for the whole of FETCH_WAIT; a fetch completes
// on the first cycle mem_req and mem_valid are both high. mem_valid in any
// other state is ignored. alu_done is accepted only in EXECUTE for ALU opcodes,
// including the first EXECUTE cycle in which instr_valid is high.
module pc_sequencer
    import bitty_pkg::*;
#(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter int         FETCH_TIMEOUT = 16,   // must be >= 1
    parameter int         EXEC_TIMEOUT  = 64    // must be >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        fetch_err,
    output logic        exec_err,
    output seq_state_t  o_dbg_state
);

    // Counter value on the last permitted cycle of each wait state.
    localparam logic [15:0] FETCH_LIMIT = 16'(FETCH_TIMEOUT - 1);
    localparam logic [15:0] EXEC_LIMIT  = 16'(EXEC_TIMEOUT - 1);

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [7:0]  r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_last_result;
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_exec_cnt;
    logic        r_instr_valid;
    logic        r_fetch_err;
    logic        r_exec_err;

    logic        w_fetch_accept;
    logic        w_fetch_timeout;
    logic        w_alu_accept;
    logic        w_exec_timeout;
    logic        w_pc_load;
    logic [7:0]  w_next_pc;
    logic        w_br_taken;

    branch_resolve u_branch_resolve (
        .i_pc          (r_pc),
        .i_is_branch   (r_instr[1:0] == OP_BR),
        .i_cond        (r_instr[3:2]),
        .i_target      (r_instr[11:4]),
        .i_last_result (r_last_result),
        .o_next_pc     (w_next_pc),
        .o_taken       (w_br_taken)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_accept  = 1'b0;
        w_fetch_timeout = 1'b0;
        w_alu_accept    = 1'b0;
        w_exec_timeout  = 1'b0;
        w_pc_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                // A response on the final permitted cycle still wins.
                if (mem_valid) begin
                    w_fetch_accept = 1'b1;
                    w_state_next   = EXECUTE;
                end else if (r_fetch_cnt == FETCH_LIMIT) begin
                    w_fetch_timeout = 1'b1;
                    w_state_next    = HALT;
                end
            end
            EXECUTE: begin
                case (r_instr[1:0])
                    OP_RR, OP_IMM: begin
                        if (alu_done) begin
                            w_alu_accept = 1'b1;
                            w_state_next = UPDATE;
                        end else if (r_exec_cnt == EXEC_LIMIT) begin
                            w_exec_timeout = 1'b1;
                            w_state_next   = HALT;
                        end
                    end
                    OP_BR:   w_state_next = UPDATE;
                    default: w_state_next = HALT;
                endcase
            end
            UPDATE: begin
                w_pc_load    = 1'b1;
                w_state_next = run ? FETCH_WAIT : IDLE;
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath registers driven by the FSM strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= 16'd0;
            r_last_result <= 16'd0;
            r_fetch_cnt   <= 16'd0;
            r_exec_cnt    <= 16'd0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_exec_err    <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_instr <= mem_rdata;
            end
            if (w_alu_accept) begin
                r_last_result <= alu_result;
            end
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_fetch_timeout) begin
                r_fetch_err <= 1'b1;
            end
            if (w_exec_timeout) begin
                r_exec_err <= 1'b1;
            end
            // Counters measure cycles spent in the current wait state and
            // restart from zero whenever that state is (re)entered.
            if ((r_state == FETCH_WAIT) && (w_state_next == FETCH_WAIT)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end else begin
                r_fetch_cnt <= 16'd0;
            end
            if ((r_state == EXECUTE) && (w_state_next == EXECUTE)) begin
                r_exec_cnt <= r_exec_cnt + 16'd1;
            end else begin
                r_exec_cnt <= 16'd0;
            end
        end
    end

    assign mem_req     = (r_state == FETCH_WAIT);
    assign mem_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign halted      = (r_state == HALT);
    assign fetch_err   = r_fetch_err;
    assign exec_err    = r_exec_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import bitty_pkg::*;

    localparam logic [7:0] RPC = 8'h00;
    localparam int         FT  = 16;
    localparam int         ET  = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic [7:0]  pc;
    logic        halted;
    logic        fetch_err;
    logic        exec_err;
    seq_state_t  dbg_state;

    pc_sequencer #(
        .RESET_PC      (RPC),
        .FETCH_TIMEOUT (FT),
        .EXEC_TIMEOUT  (ET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .pc          (pc),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .exec_err    (exec_err),
        .o_dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- memory / ALU drivers ----------------
    logic [15:0] imem [256];
    logic [15:0] ares [256];
    logic        mem_en = 1'b1;
    logic        force_valid = 1'b0;
    int          block_addr = -1;
    logic        alu_en = 1'b1;
    logic        alu_fast = 1'b0;
    logic        alu_pend = 1'b0;

    // Zero-wait memory: answers in the same cycle mem_req is seen.
    always @(negedge clk) begin
        if (force_valid) begin
            mem_valid = 1'b1;
            mem_rdata = 16'h1234;
        end else if (mem_req && mem_en && (int'(mem_addr) != block_addr)) begin
            mem_valid = 1'b1;
            mem_rdata = imem[mem_addr];
        end else begin
            mem_valid = 1'b0;
            mem_rdata = 16'hDEAD;
        end
        alu_result = ares[pc];
        if (alu_fast) begin
            alu_done = instr_valid && alu_en;
        end else begin
            alu_done = alu_pend;
            alu_pend = instr_valid && alu_en;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_final_pc;
    logic [7:0] last_addr = 8'd0;
    logic [7:0] exp_addr;

    always @(negedge clk) begin
        #1;
        if (!reset && mem_req && mem_valid && !force_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: got addr=%h, none expected", mem_addr);
            end else begin
                exp_addr = exp_q.pop_front();
                if (mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL fetch_addr: got %h expected %h", mem_addr, exp_addr);
                end
                last_addr = exp_addr;
            end
        end
        if (!reset && instr_valid) begin
            checks++;
            if (instr !== imem[last_addr]) begin
                errors++;
                $display("FAIL instr_word: got %h expected %h", instr, imem[last_addr]);
            end
        end
    end

    // Architectural model: walks the loaded program from RPC and queues the
    // fetch addresses the sequencer must produce up to the halt instruction.
    task automatic build_expected();
        logic [7:0]  p;
        logic [15:0] last;
        logic [15:0] w;
        logic        done;
        logic        taken;
        p = RPC;
        last = 16'd0;
        done = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            if (!done) begin
                exp_q.push_back(p);
                w = imem[p];
                case (w[1:0])
                    2'd0, 2'd1: begin
                        last = ares[p];
                        p = p + 8'd1;
                    end
                    2'd2: begin
                        taken = ((w[3:2] == 2'd0) && (last == 16'd0)) ||
                                ((w[3:2] == 2'd1) && (last == 16'd1)) ||
                                ((w[3:2] == 2'd2) && (last == 16'd2));
                        p = taken ? w[11:4] : p + 8'd1;
                    end
                    default: begin
                        exp_final_pc = p;
                        done = 1'b1;
                    end
                endcase
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0003;
            ares[i] = 16'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts the program and checks it ends halted at the model's final pc.
    task automatic run_program(input string name);
        int n;
        n = 0;
        @(negedge clk);
        run = 1'b1;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_halted: got %b expected 1 after %0d cycles", name, halted, n);
        end
        checks++;
        if (pc !== exp_final_pc) begin
            errors++;
            $display("FAIL %s_final_pc: got %h expected %h", name, pc, exp_final_pc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_fetches_left: got %0d expected 0", name, exp_q.size());
        end
        run = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RPC); end
        checks++;
        if (instr !== 16'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++;
        if ({mem_req, instr_valid, halted, fetch_err, exec_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {mem_req, instr_valid, halted, fetch_err, exec_err});
        end
        checks++;
        if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_run: got mem_req=%b expected 0", mem_req); end
    endtask

    task automatic test_basic_timing();
        int cnt;
        clear_mem();
        imem[0] = 16'h0000;
        ares[0] = 16'd5;
        imem[1] = 16'h0003;
        build_expected();
        do_reset();
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 8'h00)) begin
            errors++;
            $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=00", mem_req, mem_addr);
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(mem_req === 1'b1 && mem_addr === 8'h01) && cnt < 20);
        checks++;
        if (cnt != 4) begin errors++; $display("FAIL alu_latency: got %0d cycles expected 4", cnt); end
        run = 1'b0;
        run_program("basic");
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_mem_req: got %b expected 0", mem_req); end
    endtask

    task automatic test_branches();
        clear_mem();
        imem[8'h00] = 16'h0001; ares[8'h00] = 16'd0;
        imem[8'h01] = 16'h0A02;                       // cond 0 -> A0, taken
        imem[8'hA0] = 16'h0000; ares[8'hA0] = 16'd3;
        imem[8'hA1] = 16'h0A02;                       // cond 0, not taken
        imem[8'hA2] = 16'h0000; ares[8'hA2] = 16'd1;
        imem[8'hA3] = 16'h0506;                       // cond 1 -> 50, taken
        imem[8'h50] = 16'h0000; ares[8'h50] = 16'd2;
        imem[8'h51] = 16'h060A;                       // cond 2 -> 60, taken
        imem[8'h60] = 16'h0000; ares[8'h60] = 16'd7;
        imem[8'h61] = 16'h010E;                       // cond 3, never taken
        imem[8'h62] = 16'h0000; ares[8'h62] = 16'h0100;
        imem[8'h63] = 16'h0A02;                       // upper bits nonzero, not taken
        imem[8'h64] = 16'h0003;
        build_expected();
        do_reset();
        run_program("branches");
    endtask

    task automatic test_pc_wrap();
        int n;
        clear_mem();
        imem[8'h00] = 16'h0FF2;                       // last_result 0 after reset -> FF
        imem[8'hFF] = 16'h0001; ares[8'hFF] = 16'd9;
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        do_reset();
        run = 1'b1;
        n = 0;
        while (!(instr_valid === 1'b1 && pc === 8'hFF) && n < 40) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;   // instruction at FF must still complete
        n = 0;
        while (dbg_state !== IDLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(pc === 8'h00 && mem_req === 1'b0 && dbg_state === IDLE)) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h req=%b state=%0d expected pc=00 req=0 IDLE",
                     pc, mem_req, dbg_state);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_fetches_left: got %0d expected 0", exp_q.size()); end
        mem_en = 1'b0;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 8'h00)) begin
            errors++;
            $display("FAIL wrap_mem_addr: got req=%b addr=%h expected req=1 addr=00", mem_req, mem_addr);
        end
        do_reset();
        mem_en = 1'b1;
    endtask

    task automatic test_fetch_timeout();
        clear_mem();
        exp_q.delete();
        do_reset();
        mem_en = 1'b0;
        run = 1'b1;
        @(negedge clk);
        repeat (12) @(negedge clk);
        checks++;
        if (!(fetch_err === 1'b0 && halted === 1'b0 && mem_req === 1'b1)) begin
            errors++;
            $display("FAIL fetch_early: got err=%b halted=%b req=%b expected 0 0 1", fetch_err, halted, mem_req);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (!(fetch_err === 1'b1 && halted === 1'b1 && mem_req === 1'b0 && exec_err === 1'b0)) begin
            errors++;
            $display("FAIL fetch_timeout: got ferr=%b halted=%b req=%b eerr=%b expected 1 1 0 0",
                     fetch_err, halted, mem_req, exec_err);
        end
        force_valid = 1'b1;
        repeat (2) @(negedge clk);
        force_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (!(dbg_state === HALT && instr === 16'd0 && instr_valid === 1'b0)) begin
            errors++;
            $display("FAIL halt_ignores_valid: got state=%0d instr=%h iv=%b expected HALT 0000 0",
                     dbg_state, instr, instr_valid);
        end
        mem_en = 1'b1;
        do_reset();
        checks++;
        if (!(fetch_err === 1'b0 && halted === 1'b0 && dbg_state === IDLE && pc === RPC)) begin
            errors++;
            $display("FAIL reset_clears_err: got ferr=%b halted=%b state=%0d pc=%h", fetch_err, halted, dbg_state, pc);
        end
    endtask

    task automatic test_exec_timeout();
        int n;
        clear_mem();
        imem[0] = 16'h0000;
        exp_q.delete();
        exp_q.push_back(8'h00);
        alu_en = 1'b0;
        do_reset();
        run = 1'b1;
        n = 0;
        while (instr_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        checks++;
        if (!(halted === 1'b0 && exec_err === 1'b0 && dbg_state === EXECUTE)) begin
            errors++;
            $display("FAIL exec_early: got halted=%b err=%b state=%0d expected 0 0 EXECUTE", halted, exec_err, dbg_state);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (!(halted === 1'b1 && exec_err === 1'b1 && fetch_err === 1'b0 && pc === 8'h00)) begin
            errors++;
            $display("FAIL exec_timeout: got halted=%b eerr=%b ferr=%b pc=%h expected 1 1 0 00",
                     halted, exec_err, fetch_err, pc);
        end
        alu_en = 1'b1;
        do_reset();
    endtask

    task automatic test_reset_mid_fetch();
        int n;
        clear_mem();
        imem[0] = 16'h0000;
        ares[0] = 16'd4;
        exp_q.delete();
        exp_q.push_back(8'h00);
        block_addr = 1;
        do_reset();
        run = 1'b1;
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr === 8'h01) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!(pc === 8'h01 && dbg_state === FETCH_WAIT)) begin
            errors++;
            $display("FAIL pre_reset_fetch: got pc=%h state=%0d expected 01 FETCH_WAIT", pc, dbg_state);
        end
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (!(pc === RPC && mem_req === 1'b0 && dbg_state === IDLE)) begin
            errors++;
            $display("FAIL reset_mid_fetch: got pc=%h req=%b state=%0d expected %h 0 IDLE",
                     pc, mem_req, dbg_state, RPC);
        end
        reset = 1'b0;
        block_addr = -1;
    endtask

    task automatic test_back_to_back();
        clear_mem();
        imem[8'h00] = 16'h0000; ares[8'h00] = 16'd2;
        imem[8'h01] = 16'h0A0A; ares[8'h01] = 16'd0;  // cond 2 -> A0; alu_done here is ignored
        imem[8'hA0] = 16'h0003;
        build_expected();
        alu_fast = 1'b1;
        do_reset();
        run_program("fast_alu");
        alu_fast = 1'b0;
        do_reset();
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic_timing();
        test_branches();
        test_pc_wrap();
        test_fetch_timeout();
        test_exec_timeout();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 8-bit program counter and sequences every instruction through FETCH → EXECUTE → PC update for the bitty core.
- Issues instruction-memory reads over a req/valid handshake and hands the fetched word to the datapath.
- Waits for ALU completion and latches the ALU result for branch resolution.
- Resolves branches internally and replaces the free-standing combinational next-PC path with a registered one.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum cycles spent in FETCH_WAIT before a fetch error is flagged; must be ≥ 1.
- EXEC_TIMEOUT, 64, maximum cycles spent in EXECUTE awaiting alu_done; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; sequencing advances out of IDLE only while high.
- mem_req  out  1  fetch request; held high until mem_valid is seen.
- mem_addr  out  8  fetch address, equal to pc while mem_req is high.
- mem_valid  in  1  one-cycle pulse; mem_rdata is valid this cycle.
- mem_rdata  in  16  instruction word.
- instr  out  16  registered instruction currently executing.
- instr_valid  out  1  one-cycle pulse on entry to EXECUTE.
- alu_done  in  1  pulse from the datapath: the ALU op for instr is complete.
- alu_result  in  16  ALU result, valid with alu_done.
- pc  out  8  current program counter.
- halted  out  1  high in HALT.
- fetch_err  out  1  sticky; set on fetch timeout.
- exec_err  out  1  sticky; set on execute timeout.

Behaviour:
- Reset values (dominant, any state):
  - pc=RESET_PC, instr=0, last_result=0, counters=0.
  - mem_req, instr_valid, halted, fetch_err and exec_err all 0.
  - State = IDLE; any outstanding fetch or execute is abandoned.
- IDLE: when run=1, go to FETCH_WAIT and assert mem_req the next cycle.
- FETCH_WAIT:
  - mem_req=1 and mem_addr=pc.
  - On mem_valid: latch instr←mem_rdata, drop mem_req, go to EXECUTE, pulse instr_valid in the first EXECUTE cycle.
  - If the counter reaches FETCH_TIMEOUT without mem_valid: set fetch_err and go to HALT.
  - mem_valid outside FETCH_WAIT is ignored.
- EXECUTE, by opcode instr[1:0]:
  - 0 or 1 (ALU formats): wait for alu_done. On alu_done, latch last_result←alu_result and go to UPDATE. If alu_done arrives in the same cycle instr_valid is high, it is accepted. Timeout at EXEC_TIMEOUT sets exec_err and goes to HALT.
  - 2 (branch): go straight to UPDATE, no ALU wait. alu_done is ignored and last_result is not modified.
  - 3: go to HALT; pc is not advanced.
- UPDATE (exactly one cycle):
  - Non-branch: pc←pc+1.
  - Branch, cond=instr[3:2], target=instr[11:4]:
    - cond 0 with last_result==16'd0 → pc←target.
    - cond 1 with last_result==16'd1 → pc←target.
    - cond 2 with last_result==16'd2 → pc←target.
    - Otherwise pc←pc+1. cond 3 is never taken.
  - The comparison uses the full 16 bits.
  - pc arithmetic is mod 256, so 8'hFF+1 wraps to 8'h00.
  - Next state: FETCH_WAIT if run=1, else IDLE.
- HALT: absorbing; exited only by reset. halted=1, mem_req=0.
- Latency with zero-wait memory and an ALU answering 1 cycle after instr_valid: 4 cycles per ALU instruction, 3 per branch.
- run deasserted mid-instruction does not abort it; it is sampled only in IDLE and UPDATE.

Decomposition:
- Shared package bitty_pkg holds:
  - Opcode constants OP_RR=2'd0, OP_IMM=2'd1, OP_BR=2'd2, OP_HALT=2'd3.
  - Condition constants BR_EQ=0, BR_GT=1, BR_LT=2.
  - The state enum: IDLE, FETCH_WAIT, EXECUTE, UPDATE, HALT.
- One natural sub-module: branch_resolve (combinational next-PC from pc, instr and last_result).
  - This replaces the PC path of branch_logic.
  - It is instantiated once and the result is registered in UPDATE.

Test Plan:
- Reset, run=1, memory with zero wait: mem_req rises with mem_addr=0. Feed 16'h0000 and alu_done with result 5 → pc=1 and a new fetch with mem_addr=1, 4 cycles after the first mem_req.
- ALU result 0, then branch 16'h0A02 (cond 0, target 0xA0) → pc=8'hA0. Repeat with result 3 → pc=old+1.
- Branches with cond 1 after result 1 and cond 2 after result 2 → both taken. Branch with cond 3 after any result → not taken. Result 16'h0100 with cond 0 → not taken.
- pc=8'hFF with a non-branch instruction → pc wraps to 8'h00 and mem_addr=0.
- Withhold mem_valid for FETCH_TIMEOUT cycles → fetch_err=1, halted=1, mem_req=0. Later mem_valid is ignored; reset clears everything.
- Fetch instr 16'h0003 → halted=1 with pc unchanged. Assert reset mid-FETCH_WAIT → next cycle pc=RESET_PC, mem_req=0, state IDLE.
